// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline stage registers.
//   pipe_state_e : occupancy state of an elastic stage (EMPTY/FULL/SKID)
//   PIPE_DEPTH   : number of entries an elastic stage can hold
//   PAR_MAX_W    : widest payload the parity helper supports
//   even_par     : XOR-reduction parity; callers zero-extend narrower data,
//                  which leaves the parity unchanged
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  localparam int PIPE_DEPTH = 2;
  localparam int PAR_MAX_W  = 256;

  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of an elastic pipeline stage: payload, its parity bit and
// a valid flag.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   load       : capture d_data/d_par and mark the slot valid
//   clear      : empty the slot (wins over load)
//   d_data/d_par  : data and parity to capture
//   q_valid/q_data/q_par : registered slot contents
module pipe_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_par,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data,
  output logic             q_par
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             par_q, par_d;

  // Clearing zeroes the payload too, so an empty slot never shows stale data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    par_d   = par_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = '0;
      par_d   = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d_data;
      par_d   = d_par;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      par_q   <= par_d;
    end
  end

  assign q_valid = valid_q;
  assign q_data  = data_q;
  assign q_par   = par_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, flush and a
// parity-protected payload with a fault-injection hook.
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   in_valid/in_data    : upstream beat; in_ready is high unless the skid
//                         slot is occupied (registered state only)
//   inj_fault           : flips bit 0 of the beat accepted this cycle
//   flush               : synchronous squash of every held entry
//   out_valid/out_data  : main slot presented downstream, out_ready accepts
//   out_err             : stored parity disagrees with presented data
//   count               : occupancy, 0..2
module pipe_skid_reg
  import riscv_pipe_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             inj_fault,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_err,
  output logic [1:0]       count
);

  pipe_state_e state_q, state_d;

  logic                 accept;
  logic                 fire;
  logic [PAR_MAX_W-1:0] par_ext;
  logic                 in_par;
  logic [WIDTH-1:0]     in_stored;

  logic                 main_load, main_clear, main_from_skid;
  logic                 skid_load, skid_clear;
  logic [WIDTH-1:0]     main_d_data;
  logic                 main_d_par;
  logic                 main_valid, main_par;
  logic                 skid_valid, skid_par;
  logic [WIDTH-1:0]     skid_data;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  // Parity is taken from the clean input so an injected flip is detectable
  // once the beat reaches the output.
  always_comb begin
    par_ext              = '0;
    par_ext[WIDTH-1:0]   = in_data;
    in_par               = even_par(par_ext);
    in_stored            = in_data ^ WIDTH'(inj_fault);
  end

  // Next-state and slot control. Flush overrides everything: a beat accepted
  // in the same cycle is dropped, a beat fired in the same cycle is gone.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = FULL;
          end
        end
        FULL: begin
          if (accept && fire) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = SKID;
          end else if (fire) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        SKID: begin
          if (fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = FULL;
          end
        end
        default: begin
          state_d    = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // The skid slot's parity travels with its data into the main slot.
  always_comb begin
    main_d_data = main_from_skid ? skid_data : in_stored;
    main_d_par  = main_from_skid ? skid_par  : in_par;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    case (state_q)
      EMPTY:   count = 2'd0;
      FULL:    count = 2'd1;
      SKID:    count = 2'(PIPE_DEPTH);
      default: count = 2'd0;
    endcase
  end

  pipe_entry #(.WIDTH(WIDTH)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .d_data  (main_d_data),
    .d_par   (main_d_par),
    .q_valid (main_valid),
    .q_data  (out_data),
    .q_par   (main_par)
  );

  pipe_entry #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_data  (in_stored),
    .d_par   (in_par),
    .q_valid (skid_valid),
    .q_data  (skid_data),
    .q_par   (skid_par)
  );

  assign out_err = PARITY_EN & main_valid & ((^out_data) ^ main_par);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg. A parity-enabled and a
// parity-disabled instance share all inputs; both are compared every cycle
// against a queue-based model of a 2-deep FIFO stage.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        inj_fault;
  logic        flush;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_err_a;
  logic [31:0] out_data_a;
  logic [1:0]  count_a;
  logic        in_ready_b, out_valid_b, out_err_b;
  logic [31:0] out_data_b;
  logic [1:0]  count_b;

  int num_checks = 0;
  int num_errors = 0;

  // Each model entry is {parity_error_expected, stored_data}.
  logic [32:0] model_q[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32), .PARITY_EN(1'b1)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_a),
    .inj_fault (inj_fault),
    .flush     (flush),
    .out_valid (out_valid_a),
    .out_data  (out_data_a),
    .out_ready (out_ready),
    .out_err   (out_err_a),
    .count     (count_a)
  );

  pipe_skid_reg #(.WIDTH(32), .PARITY_EN(1'b0)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_b),
    .inj_fault (inj_fault),
    .flush     (flush),
    .out_valid (out_valid_b),
    .out_data  (out_data_b),
    .out_ready (out_ready),
    .out_err   (out_err_b),
    .count     (count_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Abstract stage behaviour: a FIFO of at most two beats. Readiness and
  // firing are judged on the occupancy before the edge; a flush empties it.
  task automatic model_update();
    bit acc, fir;
    acc = in_valid && (model_q.size() < 2);
    fir = (model_q.size() > 0) && out_ready;
    if (flush) begin
      model_q.delete();
    end else begin
      if (fir) void'(model_q.pop_front());
      if (acc) model_q.push_back({inj_fault, in_data ^ 32'(inj_fault)});
    end
  endtask

  task automatic check_all();
    logic [32:0] head;
    bit          exp_valid;
    exp_valid = model_q.size() > 0;
    head      = exp_valid ? model_q[0] : 33'd0;
    checkOutput("in_ready",    32'(in_ready_a),  32'(model_q.size() < 2));
    checkOutput("out_valid",   32'(out_valid_a), 32'(exp_valid));
    checkOutput("count",       32'(count_a),     32'(model_q.size()));
    checkOutput("out_err",     32'(out_err_a),   32'(head[32]));
    checkOutput("np_out_err",  32'(out_err_b),   32'd0);
    checkOutput("np_count",    32'(count_b),     32'(model_q.size()));
    if (exp_valid) begin
      checkOutput("out_data",    out_data_a, head[31:0]);
      checkOutput("np_out_data", out_data_b, head[31:0]);
    end
  endtask

  // Inputs are driven at the falling edge, the model steps at the rising
  // edge, and outputs are compared at the following falling edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d,
                               input logic inj, input logic fl,
                               input logic ordy);
    in_valid  = v;
    in_data   = d;
    inj_fault = inj;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset while the clock runs; outputs must clear without an edge.
  task automatic pulse_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    reset    = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid_a), 32'd0);
    checkOutput("rst_in_ready",  32'(in_ready_a),  32'd1);
    checkOutput("rst_count",     32'(count_a),     32'd0);
    checkOutput("rst_out_data",  out_data_a,       32'd0);
    checkOutput("rst_out_err",   32'(out_err_a),   32'd0);
    model_q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    inj_fault = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("init_in_ready", 32'(in_ready_a), 32'd1);
    checkOutput("init_count",    32'(count_a),    32'd0);
    reset = 1'b1;
    check_all();

    // Fill to two entries, then reset mid-operation.
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_count", 32'(count_a), 32'd2);
    pulse_reset();
    applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_data", out_data_a, 32'hA5A5_0001);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Streaming at one beat per cycle.
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 32'(k), 1'b0, 1'b0, 1'b1);
      checkOutput("stream_data",  out_data_a,      32'(k));
      checkOutput("stream_count", 32'(count_a),    32'd1);
      checkOutput("stream_ready", 32'(in_ready_a), 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Backpressure: two beats held, a third waits upstream.
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_count", 32'(count_a),    32'd2);
    checkOutput("bp_ready", 32'(in_ready_a), 32'd0);
    checkOutput("bp_hold",  out_data_a,      32'h11);
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_hold2", out_data_a, 32'h11);
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_out2", out_data_a, 32'h22);
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_out3", out_data_a, 32'h33);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_drained", 32'(count_a), 32'd0);

    // Flush with a simultaneous accept attempt.
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h99, 1'b0, 1'b1, 1'b0);
    checkOutput("fl_count", 32'(count_a),     32'd0);
    checkOutput("fl_valid", 32'(out_valid_a), 32'd0);
    checkOutput("fl_ready", 32'(in_ready_a),  32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("fl_no_99", 32'(out_valid_a), 32'd0);

    // Fault injection, accept+fire in FULL, then skid-to-main parity move.
    applyStimulus(1'b1, 32'hF0, 1'b1, 1'b0, 1'b0);
    checkOutput("inj_data",   out_data_a,      32'hF1);
    checkOutput("inj_err",    32'(out_err_a),  32'd1);
    checkOutput("inj_np_err", 32'(out_err_b),  32'd0);
    applyStimulus(1'b1, 32'hF0, 1'b0, 1'b0, 1'b1);
    checkOutput("sim_count",  32'(count_a),   32'd1);
    checkOutput("sim_data",   out_data_a,     32'hF0);
    checkOutput("clean_err",  32'(out_err_a), 32'd0);
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    checkOutput("skid_count", 32'(count_a), 32'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("skid_move",  out_data_a,     32'h55);
    checkOutput("skid_err",   32'(out_err_a), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Randomised traffic with occasional flushes, faults and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(249) == 0) pulse_reset();
      applyStimulus(($urandom_range(3) != 0), $urandom,
                    ($urandom_range(7) == 0), ($urandom_range(15) == 0),
                    ($urandom_range(2) != 0));
    end

    $display("test done: total=%0d bad=%0d", num_checks, num_errors);
    $finish;
  end

endmodule
